// File: rtl/mb_tx_serializer.sv
// Mainband TX serializer: buffers 64-byte flits and emits each as 4 bursts x 8 UIs on 16 lanes.
// Build option MB_TX_PARITY_EN adds parity_oPin carrying the even parity of every UI.
module mb_tx_serializer #(
  parameter int unsigned flit_buffer_size = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [7:0]  data_i [64],
  output logic        ready_o,
  output logic        valid_oPin,
  output logic [15:0] dataPins_o,
  output logic        clk_en_o
`ifdef MB_TX_PARITY_EN
  ,
  output logic        parity_oPin
`endif
);

  localparam int unsigned AW = $clog2(flit_buffer_size);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(flit_buffer_size);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  logic [511:0]  mem_q [flit_buffer_size];
  logic [511:0]  flit_in;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [4:0]    ui_q, ui_d;
  logic [511:0]  flit_q, flit_d;
  logic [15:0]   ui_bits;
  logic [15:0]   pins_q, pins_d;
  logic          valid_q, valid_d;
  logic          clk_en_q, clk_en_d;
  logic          full, empty, push, pop;
`ifdef MB_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  for (genvar b = 0; b < 64; b++) begin : g_pack
    assign flit_in[b*8 +: 8] = data_i[b];
  end

  // Lane l in the current UI carries bit ui[2:0] of byte (burst*16 + l).
  for (genvar l = 0; l < 16; l++) begin : g_lane
    assign ui_bits[l] = flit_q[{ui_q[4:3], 4'(l), ui_q[2:0]}];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= flit_in;
    end
  end

  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    push     = valid_i && !full;
    pop      = 1'b0;
    state_d  = state_q;
    ui_d     = ui_q;
    flit_d   = flit_q;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          flit_d  = mem_q[rd_ptr_q];
          ui_d    = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        ui_d = ui_q + 5'd1;
        if (ui_q == 5'd31) begin
          if (!empty) begin
            pop    = 1'b1;
            flit_d = mem_q[rd_ptr_q];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    pins_d   = (state_q == SEND) ? ui_bits : '0;
    valid_d  = (state_q == SEND) && !ui_q[2];
    clk_en_d = (state_q == SEND);
`ifdef MB_TX_PARITY_EN
    parity_d = ^pins_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      ui_q     <= '0;
      flit_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pins_q   <= '0;
      valid_q  <= 1'b0;
      clk_en_q <= 1'b0;
`ifdef MB_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ui_q     <= ui_d;
      flit_q   <= flit_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pins_q   <= pins_d;
      valid_q  <= valid_d;
      clk_en_q <= clk_en_d;
`ifdef MB_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign ready_o    = !full;
  assign dataPins_o = pins_q;
  assign valid_oPin = valid_q;
  assign clk_en_o   = clk_en_q;
`ifdef MB_TX_PARITY_EN
  assign parity_oPin = parity_q;
`endif

endmodule

// File: tb/tb_mb_tx_serializer.sv
// Self-checking bench for mb_tx_serializer: occupancy model plus flit reassembly from the pins.
module tb_mb_tx_serializer;

  localparam int DEPTH = 4;
  typedef logic [511:0] flit_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [7:0]  data_i [64];
  logic        ready_o;
  logic        valid_oPin;
  logic [15:0] dataPins_o;
  logic        clk_en_o;
`ifdef MB_TX_PARITY_EN
  logic        parity_oPin;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: FIFO occupancy and the UI position of the flit being sent (-1 = idle).
  int    m_occ   = 0;
  int    m_phase = -1;
  flit_t exp_q[$];
  flit_t cur_flit;

  bit          log_on = 1'b0;
  logic        en_log[$];
  logic        vld_log[$];
  logic        par_log[$];
  logic [15:0] pin_log[$];
  logic [15:0] sent_pins[$];
  logic        sent_vld[$];
  logic        sent_par[$];
  int          idle_bad;
  int          max_run;

  mb_tx_serializer #(.flit_buffer_size(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .valid_oPin (valid_oPin),
    .dataPins_o (dataPins_o),
    .clk_en_o   (clk_en_o)
`ifdef MB_TX_PARITY_EN
    ,
    .parity_oPin(parity_oPin)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (log_on) begin
      en_log.push_back(clk_en_o);
      vld_log.push_back(valid_oPin);
      pin_log.push_back(dataPins_o);
`ifdef MB_TX_PARITY_EN
      par_log.push_back(parity_oPin);
`endif
    end
  end

  function automatic flit_t rand_flit();
    flit_t f;
    for (int w = 0; w < 16; w++) f[w*32 +: 32] = $urandom();
    return f;
  endfunction

  task automatic set_data(input flit_t f);
    cur_flit = f;
    for (int b = 0; b < 64; b++) data_i[b] = f[b*8 +: 8];
  endtask

  task automatic tick();
    bit pop;
    bit push_ok;
    if (!reset) begin
      m_occ   = 0;
      m_phase = -1;
    end else begin
      pop     = (m_phase < 0 || m_phase == 31) && (m_occ > 0);
      push_ok = (valid_i === 1'b1) && (m_occ < DEPTH);
      if (push_ok) exp_q.push_back(cur_flit);
      m_occ = m_occ + int'(push_ok) - int'(pop);
      if (pop) m_phase = 0;
      else if (m_phase >= 0 && m_phase < 31) m_phase = m_phase + 1;
      else m_phase = -1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    en_log.delete();
    vld_log.delete();
    pin_log.delete();
    par_log.delete();
    exp_q.delete();
  endtask

  // Splits the logged pin stream into sent UIs and counts non-zero pins while the clock is gated.
  task automatic gather();
    int run;
    run = 0;
    sent_pins.delete();
    sent_vld.delete();
    sent_par.delete();
    idle_bad = 0;
    max_run  = 0;
    foreach (en_log[i]) begin
      if (en_log[i] === 1'b1) begin
        sent_pins.push_back(pin_log[i]);
        sent_vld.push_back(vld_log[i]);
`ifdef MB_TX_PARITY_EN
        sent_par.push_back(par_log[i]);
`endif
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
        if (pin_log[i] !== 16'h0000 || vld_log[i] !== 1'b0) idle_bad++;
`ifdef MB_TX_PARITY_EN
        if (par_log[i] !== 1'b0) idle_bad++;
`endif
      end
    end
  endtask

  // Inverse lane mapping: UI u, lane l holds bit (u%8) of byte (u/8)*16 + l.
  function automatic flit_t deser(int k);
    flit_t f;
    logic [15:0] w;
    f = '0;
    for (int u = 0; u < 32; u++) begin
      w = sent_pins[k*32 + u];
      for (int l = 0; l < 16; l++) f[((u / 8) * 16 + l) * 8 + (u % 8)] = w[l];
    end
    return f;
  endfunction

  task automatic drain();
    valid_i = 1'b0;
    for (int g = 0; g < 400 && (m_occ > 0 || m_phase >= 0); g++) tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    valid_i = 1'b1;
    set_data(rand_flit());
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (ready_o !== 1'b1 || dataPins_o !== 16'h0000 || valid_oPin !== 1'b0 || clk_en_o !== 1'b0)
        $display("FAIL reset_state: ready=%b pins=%h valid=%b clk_en=%b, required 1/0000/0/0",
                 ready_o, dataPins_o, valid_oPin, clk_en_o);
      else n_pass++;
    end
    reset   = 1'b1;
    valid_i = 1'b0;
    clear_logs();
    log_on = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    gather();
    n_checks++;
    if (sent_pins.size() !== 0) $display("FAIL reset_no_accept: sent UIs %0d, required 0", sent_pins.size());
    else n_pass++;
    n_checks++;
    if (idle_bad !== 0) $display("FAIL reset_idle_pins: nonzero idle samples %0d, required 0", idle_bad);
    else n_pass++;
  endtask

  task automatic test_single_flit();
    string s;
    flit_t f;
    logic [15:0] ui0;
    s = "Hello, World! This is a test. Flit 0";
    for (int b = 0; b < 64; b++) f[b*8 +: 8] = (b < s.len()) ? s[b] : 8'h20;
    for (int l = 0; l < 16; l++) ui0[l] = f[l*8];
    clear_logs();
    set_data(f);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    n_checks++;
    if (clk_en_o !== 1'b0) $display("FAIL single_lat_n0: clk_en=%b, required 0", clk_en_o);
    else n_pass++;
    tick();
    n_checks++;
    if (clk_en_o !== 1'b0) $display("FAIL single_lat_n1: clk_en=%b, required 0", clk_en_o);
    else n_pass++;
    tick();
    n_checks++;
    if (clk_en_o !== 1'b1 || dataPins_o !== ui0)
      $display("FAIL single_ui0: clk_en=%b pins=%h, required 1/%h", clk_en_o, dataPins_o, ui0);
    else n_pass++;
    for (int c = 0; c < 36; c++) tick();
    gather();
    n_checks++;
    if (sent_pins.size() !== 32 || max_run !== 32)
      $display("FAIL single_clk_en: high cycles %0d longest run %0d, required 32/32", sent_pins.size(), max_run);
    else n_pass++;
    n_checks++;
    if (en_log[2] !== 1'b1 || en_log[33] !== 1'b1 || en_log[34] !== 1'b0)
      $display("FAIL single_window: en[2]=%b en[33]=%b en[34]=%b, required 1/1/0", en_log[2], en_log[33], en_log[34]);
    else n_pass++;
    for (int u = 0; u < 32; u++) begin
      n_checks++;
      if (sent_vld[u] !== ((u % 8) < 4)) $display("FAIL single_valid_ui%0d: got %b, required %b", u, sent_vld[u], (u % 8) < 4);
      else n_pass++;
    end
    n_checks++;
    if (deser(0) !== f) $display("FAIL single_data: got %h, required %h", deser(0), f);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      set_data(rand_flit());
      valid_i = 1'b1;
      tick();
    end
    valid_i = 1'b0;
    for (int c = 0; c < 105; c++) tick();
    gather();
    n_checks++;
    if (sent_pins.size() !== 96 || max_run !== 96)
      $display("FAIL b2b_contiguous: high cycles %0d longest run %0d, required 96/96", sent_pins.size(), max_run);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (deser(k) !== exp_q[k]) $display("FAIL b2b_flit%0d: got %h, required %h", k, deser(k), exp_q[k]);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_full_fifo();
    clear_logs();
    set_data(rand_flit());
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    for (int k = 0; k < 6; k++) begin
      set_data(rand_flit());
      valid_i = 1'b1;
      tick();
      n_checks++;
      if (ready_o !== (m_occ < DEPTH)) $display("FAIL full_ready_push%0d: got %b, required %b", k, ready_o, m_occ < DEPTH);
      else n_pass++;
    end
    valid_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      n_checks++;
      if (ready_o !== (m_occ < DEPTH)) $display("FAIL full_ready_cyc%0d: got %b, required %b", c, ready_o, m_occ < DEPTH);
      else n_pass++;
    end
    for (int c = 0; c < 140; c++) tick();
    gather();
    n_checks++;
    if (sent_pins.size() !== 160) $display("FAIL full_sent_count: UIs %0d, required 160", sent_pins.size());
    else n_pass++;
    foreach (exp_q[k]) begin
      n_checks++;
      if (deser(k) !== exp_q[k]) $display("FAIL full_flit%0d: got %h, required %h", k, deser(k), exp_q[k]);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_reset_mid_flit();
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      set_data(rand_flit());
      valid_i = 1'b1;
      tick();
    end
    valid_i = 1'b0;
    for (int g = 0; g < 60 && m_phase != 13; g++) tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (dataPins_o !== 16'h0000 || valid_oPin !== 1'b0 || clk_en_o !== 1'b0 || ready_o !== 1'b1)
      $display("FAIL midreset_pins: pins=%h valid=%b clk_en=%b ready=%b, required 0000/0/0/1",
               dataPins_o, valid_oPin, clk_en_o, ready_o);
    else n_pass++;
    reset = 1'b1;
    clear_logs();
    for (int c = 0; c < 80; c++) tick();
    gather();
    n_checks++;
    if (sent_pins.size() !== 0 || idle_bad !== 0)
      $display("FAIL midreset_after: sent UIs %0d idle errors %0d, required 0/0", sent_pins.size(), idle_bad);
    else n_pass++;
  endtask

  task automatic test_random();
    clear_logs();
    for (int c = 0; c < 300; c++) begin
      set_data(rand_flit());
      valid_i = ($urandom_range(0, 9) < 2);
      tick();
      n_checks++;
      if (ready_o !== (m_occ < DEPTH)) $display("FAIL rand_ready_cyc%0d: got %b, required %b", c, ready_o, m_occ < DEPTH);
      else n_pass++;
    end
    drain();
    gather();
    n_checks++;
    if (sent_pins.size() !== 32 * exp_q.size())
      $display("FAIL rand_sent_count: UIs %0d, required %0d", sent_pins.size(), 32 * exp_q.size());
    else n_pass++;
    n_checks++;
    if (idle_bad !== 0) $display("FAIL rand_idle_pins: nonzero idle samples %0d, required 0", idle_bad);
    else n_pass++;
    foreach (exp_q[k]) begin
      n_checks++;
      if (deser(k) !== exp_q[k]) $display("FAIL rand_flit%0d: got %h, required %h", k, deser(k), exp_q[k]);
      else n_pass++;
    end
    foreach (sent_vld[i]) begin
      if (sent_vld[i] !== (((i % 32) % 8) < 4)) begin
        n_checks++;
        $display("FAIL rand_valid_ui%0d: got %b, required %b", i, sent_vld[i], ((i % 32) % 8) < 4);
      end
    end
`ifdef MB_TX_PARITY_EN
    foreach (sent_par[i]) begin
      n_checks++;
      if (sent_par[i] !== ^sent_pins[i]) $display("FAIL rand_parity_ui%0d: got %b, required %b", i, sent_par[i], ^sent_pins[i]);
      else n_pass++;
    end
`endif
  endtask

`ifdef MB_TX_PARITY_EN
  task automatic test_parity();
    flit_t f;
    clear_logs();
    set_data({512{1'b1}});
    valid_i = 1'b1;
    tick();
    f = '0;
    f[0] = 1'b1;
    set_data(f);
    tick();
    drain();
    gather();
    n_checks++;
    if (sent_par.size() !== 64) $display("FAIL parity_count: UIs %0d, required 64", sent_par.size());
    else n_pass++;
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (sent_par[i] !== (i == 32)) $display("FAIL parity_ui%0d: got %b, required %b", i, sent_par[i], i == 32);
      else n_pass++;
    end
    n_checks++;
    if (parity_oPin !== 1'b0) $display("FAIL parity_idle: got %b, required 0", parity_oPin);
    else n_pass++;
  endtask
`endif

  initial begin
    reset   = 1'b0;
    valid_i = 1'b0;
    set_data('0);
    @(negedge clk);
    test_reset();
    test_single_flit();
    test_back_to_back();
    test_full_fifo();
    test_reset_mid_flit();
    test_random();
`ifdef MB_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
